// File: rtl/my_mini_mac.sv
// Minimal 10/100 Ethernet MAC: RMII PHY side, CSR bank, 4-slot RX engine, 1-frame TX engine, 2 KiB RX/TX buffers.
// Latency: CSR read data and Wishbone ack/data one cycle after the access; RMII TX dibits registered one cycle after FSM step.
// Backpressure: none. Bus ports never stall, RX bytes beyond 1536 are dropped, and a TX start while busy is ignored.
// Ports: sys_clk/sys_rst (sync, active-high); irq_rx/irq_tx one-cycle pulses; csr_* register bank (word index adr[5:2]);
//        rx_mem_*/tx_mem_* pipelined Wishbone slaves onto the RX/TX buffers; phy_* RMII data path and bit-banged MDIO.
module my_mini_mac #(
    parameter logic [31:0] RX_MEMORY_BASE = 32'h0,
    parameter logic [31:0] TX_MEMORY_BASE = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        irq_rx,
    output logic        irq_tx,
    input  logic [31:0] csr_adr_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_dat_i,
    output logic [31:0] csr_dat_o,
    input  logic [31:0] rx_mem_adr_i,
    input  logic [31:0] rx_mem_dat_i,
    output logic [31:0] rx_mem_dat_o,
    input  logic        rx_mem_we_i,
    input  logic [3:0]  rx_mem_sel_i,
    input  logic        rx_mem_stb_i,
    output logic        rx_mem_ack_o,
    input  logic        rx_mem_cyc_i,
    output logic        rx_mem_stall_o,
    input  logic [31:0] tx_mem_adr_i,
    input  logic [31:0] tx_mem_dat_i,
    output logic [31:0] tx_mem_dat_o,
    input  logic        tx_mem_we_i,
    input  logic [3:0]  tx_mem_sel_i,
    input  logic        tx_mem_stb_i,
    output logic        tx_mem_ack_o,
    input  logic        tx_mem_cyc_i,
    output logic        tx_mem_stall_o,
    output logic        phy_mdclk,
    inout  wire         phy_mdio,
    input  logic        phy_rmii_clk,
    input  logic        phy_rmii_crs,
    input  logic [1:0]  phy_rmii_rx_data,
    output logic [1:0]  phy_rmii_tx_data,
    output logic        phy_tx_en
);
    typedef enum logic [1:0] {RX_IDLE, RX_DROP, RX_PRE, RX_DATA} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_PRE, TX_DATA, TX_END} tx_state_t;

    logic [31:0] rx_ram [0:511];
    logic [31:0] tx_ram [0:511];

    // CSR state
    logic        rx_en, tx_en, mdio_out, mdio_oe;
    logic [1:0]  slot_state [4];
    logic [10:0] slot_addr  [4];
    logic [10:0] slot_count [4];
    logic [10:0] tx_addr, tx_count;
    logic [3:0]  csr_idx;
    logic [31:0] rd_mux;

    // RX engine
    rx_state_t   rx_st;
    logic        crs_q;
    logic [1:0]  rx_slot, rx_dib, rdy_idx;
    logic        rdy_any;
    logic [10:0] rx_cnt;
    logic [5:0]  rx_sh;
    logic        rx_wr_vld;
    logic [10:0] rx_wr_adr;
    logic [7:0]  rx_wr_byte;

    // TX engine
    tx_state_t   tx_st;
    logic [4:0]  tx_pre_cnt;
    logic [1:0]  tx_dib;
    logic [7:0]  tx_sh, tx_rd_byte;
    logic [10:0] tx_ptr, tx_left;
    logic [31:0] tx_rd_word;

    logic rx_bus_acc, tx_bus_acc;
    logic unused;

    assign csr_idx        = csr_adr_i[5:2];
    assign rx_mem_stall_o = 1'b0;
    assign tx_mem_stall_o = 1'b0;
    assign rx_bus_acc = rx_mem_cyc_i & rx_mem_stb_i & (rx_mem_adr_i[31:11] == RX_MEMORY_BASE[31:11]);
    assign tx_bus_acc = tx_mem_cyc_i & tx_mem_stb_i & (tx_mem_adr_i[31:11] == TX_MEMORY_BASE[31:11]);
    assign phy_mdio   = mdio_oe ? mdio_out : 1'bz;
    assign unused     = &{1'b0, phy_rmii_clk, csr_adr_i[31:6], csr_adr_i[1:0], csr_dat_i[31:11],
                          rx_mem_adr_i[1:0], tx_mem_adr_i[1:0]};

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    assign tx_rd_byte = tx_rd_word[{~tx_ptr[1:0], 3'b000} +: 8];

    // Buffer RAMs. Bus write is issued after the engine write so it wins on a collision.
    always_ff @(posedge sys_clk) begin
        if (rx_wr_vld)
            rx_ram[rx_wr_adr[10:2]][{~rx_wr_adr[1:0], 3'b000} +: 8] <= rx_wr_byte;
        for (int b = 0; b < 4; b++) begin
            if (rx_bus_acc && rx_mem_we_i && rx_mem_sel_i[b])
                rx_ram[rx_mem_adr_i[10:2]][8*b +: 8] <= rx_mem_dat_i[8*b +: 8];
            if (tx_bus_acc && tx_mem_we_i && tx_mem_sel_i[b])
                tx_ram[tx_mem_adr_i[10:2]][8*b +: 8] <= tx_mem_dat_i[8*b +: 8];
        end
        rx_mem_dat_o <= rx_ram[rx_mem_adr_i[10:2]];
        tx_mem_dat_o <= tx_ram[tx_mem_adr_i[10:2]];
        // TX prefetch: word holding tx_ptr is ready at least 4 cycles before each byte load.
        tx_rd_word   <= tx_ram[tx_ptr[10:2]];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_mem_ack_o <= 1'b0;
            tx_mem_ack_o <= 1'b0;
        end else begin
            rx_mem_ack_o <= rx_bus_acc;
            tx_mem_ack_o <= tx_bus_acc;
        end
    end

    // Lowest-numbered slot in the ready state.
    always_comb begin
        rdy_any = 1'b0;
        rdy_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_state[i] == 2'd1) begin
                rdy_any = 1'b1;
                rdy_idx = 2'(i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_idx)
            4'd0:  rd_mux = {30'd0, rx_en, tx_en};
            4'd1:  rd_mux = {28'd0, phy_mdio, mdio_oe, mdio_out, phy_mdclk};
            4'd14: rd_mux = {21'd0, tx_addr};
            4'd15: rd_mux = {21'd0, tx_count};
            default: begin
                for (int i = 0; i < 4; i++) begin
                    if (csr_idx == 4'(2 + 3*i)) rd_mux = {30'd0, slot_state[i]};
                    if (csr_idx == 4'(3 + 3*i)) rd_mux = {21'd0, slot_addr[i]};
                    if (csr_idx == 4'(4 + 3*i)) rd_mux = {21'd0, slot_count[i]};
                end
            end
        endcase
    end

    // CSRs and both engines share one block: engine updates come last so they
    // override a same-cycle software write to the same field.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_en <= 1'b0; tx_en <= 1'b0; phy_mdclk <= 1'b0; mdio_out <= 1'b0; mdio_oe <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_state[i] <= '0; slot_addr[i] <= '0; slot_count[i] <= '0;
            end
            tx_addr <= '0; tx_count <= '0; csr_dat_o <= '0;
            rx_st <= RX_IDLE; crs_q <= 1'b0; rx_slot <= '0; rx_dib <= '0; rx_cnt <= '0; rx_sh <= '0;
            rx_wr_vld <= 1'b0; rx_wr_adr <= '0; rx_wr_byte <= '0; irq_rx <= 1'b0;
            tx_st <= TX_IDLE; tx_pre_cnt <= '0; tx_dib <= '0; tx_sh <= '0; tx_ptr <= '0; tx_left <= '0;
            phy_tx_en <= 1'b0; phy_rmii_tx_data <= 2'b00; irq_tx <= 1'b0;
        end else begin
            csr_dat_o <= rd_mux;
            if (csr_we_i) begin
                case (csr_idx)
                    4'd0:  begin rx_en <= csr_dat_i[1]; tx_en <= csr_dat_i[0]; end
                    4'd1:  begin phy_mdclk <= csr_dat_i[0]; mdio_out <= csr_dat_i[1]; mdio_oe <= csr_dat_i[2]; end
                    4'd14: tx_addr <= csr_dat_i[10:0];
                    4'd15: if (tx_st == TX_IDLE) tx_count <= csr_dat_i[10:0];
                    default: begin
                        for (int i = 0; i < 4; i++) begin
                            if (csr_idx == 4'(2 + 3*i)) slot_state[i] <= csr_dat_i[1:0];
                            if (csr_idx == 4'(3 + 3*i)) slot_addr[i]  <= csr_dat_i[10:0];
                        end
                    end
                endcase
            end

            // RX engine
            crs_q     <= phy_rmii_crs;
            rx_wr_vld <= 1'b0;
            irq_rx    <= 1'b0;
            case (rx_st)
                RX_IDLE: if (phy_rmii_crs && !crs_q) begin
                    if (rx_en && rdy_any) begin
                        rx_st   <= RX_PRE;
                        rx_slot <= rdy_idx;
                    end else begin
                        rx_st <= RX_DROP;
                    end
                end
                RX_DROP: if (!phy_rmii_crs) rx_st <= RX_IDLE;
                RX_PRE: begin
                    if (!phy_rmii_crs) begin
                        rx_st <= RX_IDLE;
                    end else if (phy_rmii_rx_data == 2'b11) begin
                        rx_st  <= RX_DATA;
                        rx_cnt <= '0;
                        rx_dib <= '0;
                    end
                end
                RX_DATA: begin
                    if (!phy_rmii_crs) begin
                        // Any partial byte in rx_sh is simply abandoned.
                        if (rx_cnt != 11'd0) begin
                            slot_state[rx_slot] <= 2'd2;
                            slot_count[rx_slot] <= rx_cnt;
                            irq_rx <= 1'b1;
                            rx_en  <= 1'b0;
                        end
                        rx_st <= RX_IDLE;
                    end else begin
                        rx_sh  <= {phy_rmii_rx_data, rx_sh[5:2]};
                        rx_dib <= rx_dib + 2'd1;
                        if (rx_dib == 2'd3 && rx_cnt < 11'd1536) begin
                            rx_wr_vld  <= 1'b1;
                            rx_wr_adr  <= slot_addr[rx_slot] + rx_cnt;
                            rx_wr_byte <= {phy_rmii_rx_data, rx_sh};
                            rx_cnt     <= rx_cnt + 11'd1;
                        end
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase

            // TX engine
            irq_tx <= 1'b0;
            case (tx_st)
                TX_IDLE: begin
                    phy_tx_en        <= 1'b0;
                    phy_rmii_tx_data <= 2'b00;
                    if (csr_we_i && csr_idx == 4'd15 && tx_en && csr_dat_i[10:0] != 11'd0) begin
                        tx_st      <= TX_PRE;
                        tx_pre_cnt <= '0;
                        tx_ptr     <= tx_addr;
                    end
                end
                TX_PRE: begin
                    // 31 dibits of 01 then 11: seven 0x55 and the 0xD5 SFD, LSB first.
                    phy_tx_en        <= 1'b1;
                    phy_rmii_tx_data <= (tx_pre_cnt == 5'd31) ? 2'b11 : 2'b01;
                    tx_pre_cnt       <= tx_pre_cnt + 5'd1;
                    if (tx_pre_cnt == 5'd31) begin
                        tx_st   <= TX_DATA;
                        tx_sh   <= tx_rd_byte;
                        tx_ptr  <= tx_ptr + 11'd1;
                        tx_dib  <= '0;
                        tx_left <= tx_count;
                    end
                end
                TX_DATA: begin
                    phy_tx_en        <= 1'b1;
                    phy_rmii_tx_data <= tx_sh[{tx_dib, 1'b0} +: 2];
                    tx_dib           <= tx_dib + 2'd1;
                    if (tx_dib == 2'd3) begin
                        tx_left <= tx_left - 11'd1;
                        if (tx_left == 11'd1) begin
                            tx_st <= TX_END;
                        end else begin
                            tx_sh  <= tx_rd_byte;
                            tx_ptr <= tx_ptr + 11'd1;
                        end
                    end
                end
                TX_END: begin
                    phy_tx_en        <= 1'b0;
                    phy_rmii_tx_data <= 2'b00;
                    irq_tx           <= 1'b1;
                    tx_count         <= '0;
                    tx_st            <= TX_IDLE;
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_my_mini_mac.sv
// Bench for my_mini_mac: CSR, Wishbone buffers, RMII RX frames and TX frame checks.
// Latency: driven and sampled on the falling edge of sys_clk.
// Backpressure: none; all waits are bounded.
module tb_my_mini_mac;
    localparam logic [31:0] RXB = 32'h8000_0000;
    localparam logic [31:0] TXB = 32'h8000_0800;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        irq_rx, irq_tx;
    logic [31:0] csr_adr_i = '0, csr_dat_i = '0, csr_dat_o;
    logic        csr_we_i = 1'b0;
    logic [31:0] rx_mem_adr_i = '0, rx_mem_dat_i = '0, rx_mem_dat_o;
    logic        rx_mem_we_i = 1'b0, rx_mem_stb_i = 1'b0, rx_mem_cyc_i = 1'b0, rx_mem_ack_o, rx_mem_stall_o;
    logic [3:0]  rx_mem_sel_i = '0;
    logic [31:0] tx_mem_adr_i = '0, tx_mem_dat_i = '0, tx_mem_dat_o;
    logic        tx_mem_we_i = 1'b0, tx_mem_stb_i = 1'b0, tx_mem_cyc_i = 1'b0, tx_mem_ack_o, tx_mem_stall_o;
    logic [3:0]  tx_mem_sel_i = '0;
    logic        phy_mdclk;
    wire         phy_mdio;
    logic        mdio_tb = 1'b0, mdio_tb_oe = 1'b1;
    logic        phy_rmii_crs = 1'b0;
    logic [1:0]  phy_rmii_rx_data = 2'b00, phy_rmii_tx_data;
    logic        phy_tx_en;

    assign phy_mdio = mdio_tb_oe ? mdio_tb : 1'bz;

    my_mini_mac #(.RX_MEMORY_BASE(RXB), .TX_MEMORY_BASE(TXB)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .irq_rx(irq_rx), .irq_tx(irq_tx),
        .csr_adr_i(csr_adr_i), .csr_we_i(csr_we_i), .csr_dat_i(csr_dat_i), .csr_dat_o(csr_dat_o),
        .rx_mem_adr_i(rx_mem_adr_i), .rx_mem_dat_i(rx_mem_dat_i), .rx_mem_dat_o(rx_mem_dat_o),
        .rx_mem_we_i(rx_mem_we_i), .rx_mem_sel_i(rx_mem_sel_i), .rx_mem_stb_i(rx_mem_stb_i),
        .rx_mem_ack_o(rx_mem_ack_o), .rx_mem_cyc_i(rx_mem_cyc_i), .rx_mem_stall_o(rx_mem_stall_o),
        .tx_mem_adr_i(tx_mem_adr_i), .tx_mem_dat_i(tx_mem_dat_i), .tx_mem_dat_o(tx_mem_dat_o),
        .tx_mem_we_i(tx_mem_we_i), .tx_mem_sel_i(tx_mem_sel_i), .tx_mem_stb_i(tx_mem_stb_i),
        .tx_mem_ack_o(tx_mem_ack_o), .tx_mem_cyc_i(tx_mem_cyc_i), .tx_mem_stall_o(tx_mem_stall_o),
        .phy_mdclk(phy_mdclk), .phy_mdio(phy_mdio), .phy_rmii_clk(sys_clk),
        .phy_rmii_crs(phy_rmii_crs), .phy_rmii_rx_data(phy_rmii_rx_data),
        .phy_rmii_tx_data(phy_rmii_tx_data), .phy_tx_en(phy_tx_en)
    );

    always #10 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_irq_rx = 0;
    int n_irq_tx = 0;
    logic [1:0]  tx_exp [$];
    logic [31:0] rd_exp [$];
    logic [7:0]  frame_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse counters: a pulse held for two cycles counts twice.
    always @(negedge sys_clk) begin
        if (!sys_rst && irq_rx) n_irq_rx++;
        if (!sys_rst && irq_tx) n_irq_tx++;
    end

    // TX scoreboard: every dibit on the wire must match the next expected one.
    always @(negedge sys_clk) begin
        if (!sys_rst && phy_tx_en) begin
            if (tx_exp.size() == 0) chk("tx_extra_dibit", {30'd0, phy_rmii_tx_data}, 32'hFFFF_FFFF);
            else chk("tx_dibit", {30'd0, phy_rmii_tx_data}, {30'd0, tx_exp.pop_front()});
        end
    end

    task automatic csr_wr(input int idx, input logic [31:0] d);
        @(negedge sys_clk);
        csr_adr_i = 32'(idx * 4); csr_dat_i = d; csr_we_i = 1'b1;
        @(negedge sys_clk);
        csr_we_i = 1'b0;
    endtask

    task automatic csr_chk(input int idx, input logic [31:0] exp, input string tag);
        @(negedge sys_clk);
        csr_adr_i = 32'(idx * 4); csr_we_i = 1'b0;
        @(negedge sys_clk);
        chk(tag, csr_dat_o, exp);
    endtask

    task automatic wb_cycle(input bit tx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                            input bit we, output logic ack, output logic [31:0] rdat);
        @(negedge sys_clk);
        if (tx) begin
            tx_mem_adr_i = a; tx_mem_dat_i = d; tx_mem_sel_i = sel; tx_mem_we_i = we;
            tx_mem_cyc_i = 1'b1; tx_mem_stb_i = 1'b1;
        end else begin
            rx_mem_adr_i = a; rx_mem_dat_i = d; rx_mem_sel_i = sel; rx_mem_we_i = we;
            rx_mem_cyc_i = 1'b1; rx_mem_stb_i = 1'b1;
        end
        @(negedge sys_clk);
        ack  = tx ? tx_mem_ack_o : rx_mem_ack_o;
        rdat = tx ? tx_mem_dat_o : rx_mem_dat_o;
        tx_mem_cyc_i = 1'b0; tx_mem_stb_i = 1'b0; tx_mem_we_i = 1'b0;
        rx_mem_cyc_i = 1'b0; rx_mem_stb_i = 1'b0; rx_mem_we_i = 1'b0;
    endtask

    task automatic wb_wr(input bit tx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic ack;
        logic [31:0] rdat;
        wb_cycle(tx, a, d, sel, 1'b1, ack, rdat);
        chk("wb_wr_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic wb_rd(input bit tx, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic ack;
        logic [31:0] rdat;
        rd_exp.push_back(exp);
        wb_cycle(tx, a, 32'd0, 4'hF, 1'b0, ack, rdat);
        chk("wb_rd_ack", {31'd0, ack}, 32'd1);
        chk(tag, rdat, rd_exp.pop_front());
    endtask

    // n_pre dibits of 01; with_sfd appends the SFD tail and the bytes in frame_q.
    task automatic send_frame(input int n_pre, input bit with_sfd);
        logic [1:0] d [$];
        logic [7:0] b;
        for (int i = 0; i < n_pre; i++) d.push_back(2'b01);
        if (with_sfd) begin
            d.push_back(2'b01); d.push_back(2'b01); d.push_back(2'b01); d.push_back(2'b11);
            foreach (frame_q[i]) begin
                b = frame_q[i];
                for (int k = 0; k < 4; k++) d.push_back(b[2*k +: 2]);
            end
        end
        foreach (d[i]) begin
            @(negedge sys_clk);
            phy_rmii_crs = 1'b1; phy_rmii_rx_data = d[i];
        end
        @(negedge sys_clk);
        phy_rmii_crs = 1'b0; phy_rmii_rx_data = 2'b00;
        repeat (4) @(negedge sys_clk);
    endtask

    initial begin
        logic ack;
        logic [31:0] rdat;
        logic [7:0] tb_bytes [10];
        int irq_base;
        int waited;

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;

        // Reset state
        chk("rst_tx_en", {31'd0, phy_tx_en}, 32'd0);
        chk("rst_irq", {30'd0, irq_rx, irq_tx}, 32'd0);
        chk("rst_ack", {30'd0, rx_mem_ack_o, tx_mem_ack_o}, 32'd0);
        chk("rst_csr_dat", csr_dat_o, 32'd0);
        for (int r = 0; r < 16; r++) csr_chk(r, 32'd0, $sformatf("rst_reg%0d", r));

        // MDIO bit-bang and pin readback
        csr_wr(1, 32'h1);
        chk("mdc_out", {31'd0, phy_mdclk}, 32'd1);
        csr_chk(1, 32'h1, "mdio_rd_pin0");
        mdio_tb = 1'b1;
        csr_chk(1, 32'h9, "mdio_rd_pin1");
        csr_wr(1, 32'h0);

        // Bus byte enables and address miss
        wb_wr(1'b0, RXB + 4, 32'hAABB_CCDD, 4'hF);
        wb_wr(1'b0, RXB + 4, 32'h0000_1100, 4'b0010);
        wb_rd(1'b0, RXB + 4, 32'hAABB_11DD, "wb_sel_byte1");
        wb_cycle(1'b0, 32'h8000_1000, 32'h1234_5678, 4'hF, 1'b1, ack, rdat);
        chk("wb_miss_noack", {31'd0, ack}, 32'd0);
        wb_rd(1'b0, RXB + 4, 32'hAABB_11DD, "wb_miss_nowrite");
        wb_cycle(1'b1, 32'h8000_0000, 32'h0, 4'hF, 1'b0, ack, rdat);
        chk("tx_wb_miss_noack", {31'd0, ack}, 32'd0);

        // Basic RX into slot 2 at offset 8
        wb_wr(1'b0, RXB + 12, 32'h0, 4'hF);
        csr_wr(9, 32'd8);
        csr_wr(8, 32'd1);
        csr_wr(0, 32'd2);
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(28, 1'b1);
        chk("rx1_irq_cnt", 32'(n_irq_rx), 32'd1);
        csr_chk(8, 32'd2, "rx1_state2");
        csr_chk(10, 32'd5, "rx1_count2");
        csr_chk(0, 32'd0, "rx1_ctrl_cleared");
        csr_chk(2, 32'd0, "rx1_state0_untouched");
        wb_rd(1'b0, RXB + 8, 32'h0102_0304, "rx1_word2");
        wb_rd(1'b0, RXB + 12, 32'h0500_0000, "rx1_word3");

        // No ready slot: dropped
        csr_wr(0, 32'd2);
        send_frame(28, 1'b1);
        chk("noslot_irq_cnt", 32'(n_irq_rx), 32'd1);
        csr_chk(8, 32'd2, "noslot_state2");
        csr_chk(0, 32'd2, "noslot_ctrl");

        // Ready slot but rx disabled: dropped
        csr_wr(2, 32'd1);
        csr_wr(0, 32'd0);
        send_frame(28, 1'b1);
        chk("rxoff_irq_cnt", 32'(n_irq_rx), 32'd1);
        csr_chk(2, 32'd1, "rxoff_state0");
        csr_chk(4, 32'd0, "rxoff_count0");

        // Carrier drop before SFD: nothing recorded
        csr_wr(0, 32'd2);
        send_frame(10, 1'b0);
        chk("earlydrop_irq_cnt", 32'(n_irq_rx), 32'd1);
        csr_chk(2, 32'd1, "earlydrop_state0");
        csr_chk(0, 32'd2, "earlydrop_ctrl");

        // Oversize frame into slot 0 at offset 0: saturates at 1536 bytes
        wb_wr(1'b0, RXB + 1536, 32'hDEAD_BEEF, 4'hF);
        wb_wr(1'b0, RXB + 2044, 32'hCAFE_F00D, 4'hF);
        frame_q = {};
        for (int i = 0; i < 1600; i++) frame_q.push_back(8'(i));
        send_frame(28, 1'b1);
        chk("big_irq_cnt", 32'(n_irq_rx), 32'd2);
        csr_chk(4, 32'd1536, "big_count0");
        csr_chk(2, 32'd2, "big_state0");
        wb_rd(1'b0, RXB + 0, 32'h0001_0203, "big_word0");
        wb_rd(1'b0, RXB + 1532, 32'hFCFD_FEFF, "big_word383");
        wb_rd(1'b0, RXB + 1536, 32'hDEAD_BEEF, "big_no_overrun");
        wb_rd(1'b0, RXB + 2044, 32'hCAFE_F00D, "big_no_overrun_end");

        // TX of 10 bytes from offset 0
        wb_wr(1'b1, TXB + 0, 32'h1122_3344, 4'hF);
        wb_wr(1'b1, TXB + 4, 32'h5566_7788, 4'hF);
        wb_wr(1'b1, TXB + 8, 32'h99AA_BBCC, 4'hF);
        wb_rd(1'b1, TXB + 4, 32'h5566_7788, "tx_ram_rb");
        csr_wr(0, 32'd1);
        csr_wr(14, 32'd0);
        tb_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        for (int i = 0; i < 31; i++) tx_exp.push_back(2'b01);
        tx_exp.push_back(2'b11);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 4; k++) tx_exp.push_back(tb_bytes[i][2*k +: 2]);
        irq_base = n_irq_tx;
        csr_wr(15, 32'd10);
        csr_chk(15, 32'd10, "tx_count_busy");
        csr_wr(15, 32'd3);
        csr_chk(15, 32'd10, "tx_busy_write_ignored");
        waited = 0;
        while (n_irq_tx == irq_base && waited < 300) begin
            @(negedge sys_clk);
            waited++;
        end
        if (n_irq_tx == irq_base) chk("tx_irq_timeout", 32'(waited), 32'd0);
        repeat (3) @(negedge sys_clk);
        chk("tx_irq_cnt", 32'(n_irq_tx - irq_base), 32'd1);
        chk("tx_dibits_left", 32'(tx_exp.size()), 32'd0);
        chk("tx_en_after", {31'd0, phy_tx_en}, 32'd0);
        csr_chk(15, 32'd0, "tx_count_done");
        chk("rx_irq_unchanged", 32'(n_irq_rx), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end
endmodule
